// File: rtl/idli_sqi_arb_m.sv
// idli_sqi_arb_m: shares the single SQI serial-RAM port between the fetch and
// data requesters. Picks a winner, then sequences CMD, 24-bit ADDR, DUMMY (reads)
// and nibble-serial DATA, with sequential 16-bit-word bursts.
// Optional feature macro: IDLI_SQI_ARB_FAIR_EN (round-robin arbitration and
// MAX_BURST-limited bursts). Without it data has fixed priority and bursts are
// unlimited.
module idli_sqi_arb_m #(
  parameter int MAX_BURST = 4
) (
  input  logic        i_arb_gck,
  input  logic        i_arb_rst,
  input  logic        i_arb_f_req,
  input  logic [15:0] i_arb_f_addr,
  output logic        o_arb_f_gnt,
  input  logic        i_arb_d_req,
  input  logic        i_arb_d_wr,
  input  logic [15:0] i_arb_d_addr,
  output logic        o_arb_d_gnt,
  input  logic [3:0]  i_arb_d_wr_data,
  output logic        o_arb_wr_acp,
  output logic [3:0]  o_arb_rd_data,
  output logic        o_arb_rd_vld,
  output logic        o_arb_word_last,
  output logic        o_arb_sqi_sck,
  output logic        o_arb_sqi_cs,
  output logic        o_arb_sqi_mode,
  input  logic [3:0]  i_arb_sqi_data,
  output logic [3:0]  o_arb_sqi_data
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4
  } state_t;

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("MAX_BURST must be at least 1");
  end

  // Nibble idx (0 = most significant) of the byte address {7'b0, addr, 1'b0}
  function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [2:0] idx);
    logic [23:0] ba;
    ba = {7'b0, addr, 1'b0};
    case (idx)
      3'd0:    addr_nibble = ba[23:20];
      3'd1:    addr_nibble = ba[19:16];
      3'd2:    addr_nibble = ba[15:12];
      3'd3:    addr_nibble = ba[11:8];
      3'd4:    addr_nibble = ba[7:4];
      3'd5:    addr_nibble = ba[3:0];
      default: addr_nibble = 4'h0;
    endcase
  endfunction

  state_t      state_r;
  logic [3:0]  phase_r;
  logic [15:0] addr_r;
  logic        wr_r;
  logic        own_d_r;
  logic        f_gnt_r;
  logic        d_gnt_r;
  logic        sck_r;
  logic        cs_r;
  logic        mode_r;
  logic [3:0]  sqi_data_r;
  logic [3:0]  rd_data_r;
  logic        rd_vld_r;
  logic        wr_acp_r;
  logic        word_last_r;

  logic        pick_d_s;
  logic        owner_req_s;
  logic        continue_s;

`ifdef IDLI_SQI_ARB_FAIR_EN
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic          last_d_r;
  logic [BW-1:0] burst_r;
  logic          other_req_s;
  logic          burst_full_s;

  // Burst is full once the word now finishing reaches MAX_BURST
  assign burst_full_s = (int'(burst_r) >= (MAX_BURST - 1));

  // Remember the last winner and count completed words of the current burst
  always_ff @(posedge i_arb_gck) begin
    if (i_arb_rst) begin
      last_d_r <= 1'b0;
      burst_r  <= '0;
    end else if ((state_r == ST_IDLE) && (i_arb_f_req || i_arb_d_req)) begin
      last_d_r <= pick_d_s;
      burst_r  <= '0;
    end else if ((state_r == ST_DATA) && (phase_r == 4'd3) && !burst_full_s) begin
      burst_r  <= burst_r + BW'(1);
    end
  end
`endif

  // Pick the IDLE winner and decide whether the owner's burst may go on
  always_comb begin
    owner_req_s = own_d_r ? i_arb_d_req : i_arb_f_req;
`ifdef IDLI_SQI_ARB_FAIR_EN
    other_req_s = own_d_r ? i_arb_f_req : i_arb_d_req;
    pick_d_s    = i_arb_d_req & (~i_arb_f_req | ~last_d_r);
    continue_s  = owner_req_s & ~(other_req_s & burst_full_s);
`else
    pick_d_s    = i_arb_d_req;
    continue_s  = owner_req_s;
`endif
  end

  // Transaction sequencer; every pin-facing output is registered here
  always_ff @(posedge i_arb_gck) begin
    if (i_arb_rst) begin
      state_r     <= ST_IDLE;
      phase_r     <= 4'd0;
      addr_r      <= 16'd0;
      wr_r        <= 1'b0;
      own_d_r     <= 1'b0;
      f_gnt_r     <= 1'b0;
      d_gnt_r     <= 1'b0;
      sck_r       <= 1'b0;
      cs_r        <= 1'b1;
      mode_r      <= 1'b0;
      sqi_data_r  <= 4'h0;
      rd_data_r   <= 4'h0;
      rd_vld_r    <= 1'b0;
      wr_acp_r    <= 1'b0;
      word_last_r <= 1'b0;
    end else begin
      rd_vld_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_arb_f_req || i_arb_d_req) begin
            state_r    <= ST_CMD;
            phase_r    <= 4'd0;
            own_d_r    <= pick_d_s;
            addr_r     <= pick_d_s ? i_arb_d_addr : i_arb_f_addr;
            wr_r       <= pick_d_s & i_arb_d_wr;
            f_gnt_r    <= ~pick_d_s;
            d_gnt_r    <= pick_d_s;
            cs_r       <= 1'b0;
            sck_r      <= 1'b1;
            mode_r     <= 1'b1;
            sqi_data_r <= 4'h0;
          end
        end
        ST_CMD: begin
          if (phase_r == 4'd0) begin
            phase_r    <= 4'd1;
            sqi_data_r <= wr_r ? 4'h2 : 4'h3;
          end else begin
            state_r    <= ST_ADDR;
            phase_r    <= 4'd0;
            sqi_data_r <= addr_nibble(addr_r, 3'd0);
          end
        end
        ST_ADDR: begin
          if (phase_r != 4'd5) begin
            phase_r    <= phase_r + 4'd1;
            sqi_data_r <= addr_nibble(addr_r, phase_r[2:0] + 3'd1);
          end else if (wr_r) begin
            state_r    <= ST_DATA;
            phase_r    <= 4'd0;
            wr_acp_r   <= 1'b1;
            sqi_data_r <= 4'h0;
          end else begin
            state_r    <= ST_DUMMY;
            phase_r    <= 4'd0;
            mode_r     <= 1'b0;
            sqi_data_r <= 4'h0;
          end
        end
        ST_DUMMY: begin
          if (phase_r == 4'd0) begin
            phase_r <= 4'd1;
          end else begin
            state_r <= ST_DATA;
            phase_r <= 4'd0;
          end
        end
        ST_DATA: begin
          if (!wr_r) begin
            rd_data_r <= i_arb_sqi_data;
            rd_vld_r  <= 1'b1;
          end
          if (phase_r != 4'd3) begin
            phase_r     <= phase_r + 4'd1;
            word_last_r <= (phase_r == 4'd2);
          end else if (continue_s) begin
            phase_r     <= 4'd0;
            word_last_r <= 1'b0;
          end else begin
            state_r     <= ST_IDLE;
            phase_r     <= 4'd0;
            cs_r        <= 1'b1;
            sck_r       <= 1'b0;
            mode_r      <= 1'b0;
            f_gnt_r     <= 1'b0;
            d_gnt_r     <= 1'b0;
            wr_acp_r    <= 1'b0;
            word_last_r <= 1'b0;
            sqi_data_r  <= 4'h0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          phase_r     <= 4'd0;
          cs_r        <= 1'b1;
          sck_r       <= 1'b0;
          mode_r      <= 1'b0;
          f_gnt_r     <= 1'b0;
          d_gnt_r     <= 1'b0;
          wr_acp_r    <= 1'b0;
          word_last_r <= 1'b0;
          sqi_data_r  <= 4'h0;
        end
      endcase
    end
  end

  // Write nibbles pass straight from the requester while the port accepts them
  assign o_arb_sqi_data  = wr_acp_r ? i_arb_d_wr_data : sqi_data_r;
  assign o_arb_f_gnt     = f_gnt_r;
  assign o_arb_d_gnt     = d_gnt_r;
  assign o_arb_wr_acp    = wr_acp_r;
  assign o_arb_rd_data   = rd_data_r;
  assign o_arb_rd_vld    = rd_vld_r;
  assign o_arb_word_last = word_last_r;
  assign o_arb_sqi_sck   = sck_r;
  assign o_arb_sqi_cs    = cs_r;
  assign o_arb_sqi_mode  = mode_r;

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Self-checking bench for idli_sqi_arb_m: directed test-plan scenarios plus a
// randomized run against a cycle-index based transaction model.
module tb_idli_sqi_arb_m;

  localparam int MB = 4;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic        d_gnt;
  logic [3:0]  wr_data;
  logic        wr_acp;
  logic [3:0]  rd_data;
  logic        rd_vld;
  logic        word_last;
  logic        sck;
  logic        cs;
  logic        mode;
  logic [3:0]  sqi_in;
  logic [3:0]  sqi_out;

  int total = 0;
  int bad   = 0;

  idli_sqi_arb_m #(.MAX_BURST(MB)) dut (
    .i_arb_gck       (clk),
    .i_arb_rst       (rst),
    .i_arb_f_req     (f_req),
    .i_arb_f_addr    (f_addr),
    .o_arb_f_gnt     (f_gnt),
    .i_arb_d_req     (d_req),
    .i_arb_d_wr      (d_wr),
    .i_arb_d_addr    (d_addr),
    .o_arb_d_gnt     (d_gnt),
    .i_arb_d_wr_data (wr_data),
    .o_arb_wr_acp    (wr_acp),
    .o_arb_rd_data   (rd_data),
    .o_arb_rd_vld    (rd_vld),
    .o_arb_word_last (word_last),
    .o_arb_sqi_sck   (sck),
    .o_arb_sqi_cs    (cs),
    .o_arb_sqi_mode  (mode),
    .i_arb_sqi_data  (sqi_in),
    .o_arb_sqi_data  (sqi_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse followed by one idle cycle, requests low
  task automatic settle();
    step();
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    f_addr = 16'h0; d_addr = 16'h0; wr_data = 4'h0; sqi_in = 4'h0;
    repeat (3) step();
    #1;
    total++; if (cs !== 1'b1)        begin bad++; $display("FAIL reset_cs got=%0b exp=1", cs); end
    total++; if (sck !== 1'b0)       begin bad++; $display("FAIL reset_sck got=%0b exp=0", sck); end
    total++; if (mode !== 1'b0)      begin bad++; $display("FAIL reset_mode got=%0b exp=0", mode); end
    total++; if (sqi_out !== 4'h0)   begin bad++; $display("FAIL reset_sqi_data got=%0h exp=0", sqi_out); end
    total++; if (f_gnt !== 1'b0)     begin bad++; $display("FAIL reset_f_gnt got=%0b exp=0", f_gnt); end
    total++; if (d_gnt !== 1'b0)     begin bad++; $display("FAIL reset_d_gnt got=%0b exp=0", d_gnt); end
    total++; if (rd_data !== 4'h0)   begin bad++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    total++; if (rd_vld !== 1'b0)    begin bad++; $display("FAIL reset_rd_vld got=%0b exp=0", rd_vld); end
    total++; if (wr_acp !== 1'b0)    begin bad++; $display("FAIL reset_wr_acp got=%0b exp=0", wr_acp); end
    total++; if (word_last !== 1'b0) begin bad++; $display("FAIL reset_word_last got=%0b exp=0", word_last); end
    rst = 1'b0;
  endtask

  task automatic test_fetch_read();
    logic [3:0] exp_ca [8];
    logic [3:0] mem [4];
    exp_ca = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};
    mem    = '{4'hA, 4'hB, 4'hC, 4'hD};
    settle();
    f_req = 1'b1; f_addr = 16'h1234;
    for (int k = 1; k <= 16; k++) begin
      step();
      f_req  = 1'b0;
      sqi_in = (k >= 11 && k <= 14) ? mem[k-11] : 4'($urandom);
      #1;
      total++; if (cs !== !(k <= 14))  begin bad++; $display("FAIL fr_cs cyc=%0d got=%0b exp=%0b", k, cs, !(k <= 14)); end
      total++; if (sck !== (k <= 14))  begin bad++; $display("FAIL fr_sck cyc=%0d got=%0b exp=%0b", k, sck, (k <= 14)); end
      total++; if (mode !== (k <= 8))  begin bad++; $display("FAIL fr_mode cyc=%0d got=%0b exp=%0b", k, mode, (k <= 8)); end
      total++; if (f_gnt !== (k <= 14)) begin bad++; $display("FAIL fr_f_gnt cyc=%0d got=%0b exp=%0b", k, f_gnt, (k <= 14)); end
      total++; if (d_gnt !== 1'b0)     begin bad++; $display("FAIL fr_d_gnt cyc=%0d got=%0b exp=0", k, d_gnt); end
      total++; if (word_last !== (k == 14)) begin bad++; $display("FAIL fr_word_last cyc=%0d got=%0b exp=%0b", k, word_last, (k == 14)); end
      total++; if (rd_vld !== (k >= 12 && k <= 15)) begin bad++; $display("FAIL fr_rd_vld cyc=%0d got=%0b exp=%0b", k, rd_vld, (k >= 12 && k <= 15)); end
      if (k <= 8) begin
        total++; if (sqi_out !== exp_ca[k-1]) begin bad++; $display("FAIL fr_sqi_data cyc=%0d got=%0h exp=%0h", k, sqi_out, exp_ca[k-1]); end
      end else if (k <= 10) begin
        total++; if (sqi_out !== 4'h0) begin bad++; $display("FAIL fr_dummy_data cyc=%0d got=%0h exp=0", k, sqi_out); end
      end else if (k >= 12 && k <= 15) begin
        total++; if (rd_data !== mem[k-12]) begin bad++; $display("FAIL fr_rd_data cyc=%0d got=%0h exp=%0h", k, rd_data, mem[k-12]); end
      end
    end
  endtask

  task automatic test_data_write();
    logic [3:0] exp_ca [8];
    logic [3:0] nib [4];
    exp_ca = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
    nib    = '{4'h5, 4'h6, 4'h7, 4'h8};
    settle();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0001;
    for (int k = 1; k <= 14; k++) begin
      step();
      d_req   = 1'b0;
      d_wr    = 1'($urandom);
      wr_data = (k >= 9 && k <= 12) ? nib[k-9] : 4'($urandom);
      #1;
      total++; if (cs !== !(k <= 12))   begin bad++; $display("FAIL dw_cs cyc=%0d got=%0b exp=%0b", k, cs, !(k <= 12)); end
      total++; if (mode !== (k <= 12))  begin bad++; $display("FAIL dw_mode cyc=%0d got=%0b exp=%0b", k, mode, (k <= 12)); end
      total++; if (d_gnt !== (k <= 12)) begin bad++; $display("FAIL dw_d_gnt cyc=%0d got=%0b exp=%0b", k, d_gnt, (k <= 12)); end
      total++; if (wr_acp !== (k >= 9 && k <= 12)) begin bad++; $display("FAIL dw_wr_acp cyc=%0d got=%0b exp=%0b", k, wr_acp, (k >= 9 && k <= 12)); end
      total++; if (word_last !== (k == 12)) begin bad++; $display("FAIL dw_word_last cyc=%0d got=%0b exp=%0b", k, word_last, (k == 12)); end
      total++; if (rd_vld !== 1'b0)     begin bad++; $display("FAIL dw_rd_vld cyc=%0d got=%0b exp=0", k, rd_vld); end
      if (k <= 8) begin
        total++; if (sqi_out !== exp_ca[k-1]) begin bad++; $display("FAIL dw_sqi_data cyc=%0d got=%0h exp=%0h", k, sqi_out, exp_ca[k-1]); end
      end else if (k <= 12) begin
        total++; if (sqi_out !== nib[k-9]) begin bad++; $display("FAIL dw_wr_nibble cyc=%0d got=%0h exp=%0h", k, sqi_out, nib[k-9]); end
      end
    end
    d_wr = 1'b0;
  endtask

  task automatic test_burst();
    int mode_cnt = 0;
    int vld_cnt  = 0;
    settle();
    f_req = 1'b1; f_addr = 16'($urandom);
    for (int k = 1; k <= 24; k++) begin
      step();
      f_req  = (k <= 18);
      sqi_in = 4'($urandom);
      #1;
      if (mode === 1'b1) mode_cnt++;
      if (rd_vld === 1'b1) vld_cnt++;
      total++; if (word_last !== (k == 14 || k == 18 || k == 22)) begin bad++; $display("FAIL bu_word_last cyc=%0d got=%0b exp=%0b", k, word_last, (k == 14 || k == 18 || k == 22)); end
      total++; if (cs !== (k >= 23)) begin bad++; $display("FAIL bu_cs cyc=%0d got=%0b exp=%0b", k, cs, (k >= 23)); end
    end
    total++; if (mode_cnt != 8)  begin bad++; $display("FAIL bu_cmd_addr_cycles got=%0d exp=8", mode_cnt); end
    total++; if (vld_cnt != 12)  begin bad++; $display("FAIL bu_data_cycles got=%0d exp=12", vld_cnt); end
  endtask

`ifdef IDLI_SQI_ARB_FAIR_EN
  task automatic test_fair();
    bit e_f, e_d, e_wl;
    settle();
    f_req = 1'b1; f_addr = 16'($urandom); d_addr = 16'($urandom); d_wr = 1'b0;
    for (int k = 1; k <= 46; k++) begin
      step();
      f_req  = (k <= 42);
      d_req  = (k >= 16 && k <= 27) || (k == 42);
      sqi_in = 4'($urandom);
      #1;
      e_f  = (k <= 26) || (k >= 43);
      e_d  = (k >= 28 && k <= 41);
      e_wl = (k == 14 || k == 18 || k == 22 || k == 26 || k == 41);
      total++; if (f_gnt !== e_f) begin bad++; $display("FAIL fair_f_gnt cyc=%0d got=%0b exp=%0b", k, f_gnt, e_f); end
      total++; if (d_gnt !== e_d) begin bad++; $display("FAIL fair_d_gnt cyc=%0d got=%0b exp=%0b", k, d_gnt, e_d); end
      total++; if (cs !== !(e_f || e_d)) begin bad++; $display("FAIL fair_cs cyc=%0d got=%0b exp=%0b", k, cs, !(e_f || e_d)); end
      total++; if (word_last !== e_wl) begin bad++; $display("FAIL fair_word_last cyc=%0d got=%0b exp=%0b", k, word_last, e_wl); end
    end
    f_req = 1'b0; d_req = 1'b0;
  endtask
`else
  task automatic test_prio();
    bit tog  = 1'b0;
    bit prev = 1'b0;
    int txns = 0;
    settle();
    f_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (word_last === 1'b1) tog = ~tog;
      d_req   = !(word_last === 1'b1 && tog);
      d_wr    = 1'($urandom);
      d_addr  = 16'($urandom);
      f_addr  = 16'($urandom);
      sqi_in  = 4'($urandom);
      wr_data = 4'($urandom);
      #1;
      if (d_gnt === 1'b1 && !prev) txns++;
      prev = (d_gnt === 1'b1);
      total++; if (f_gnt !== 1'b0) begin bad++; $display("FAIL prio_f_gnt cyc=%0d got=%0b exp=0", k, f_gnt); end
      total++; if (d_gnt !== !cs)  begin bad++; $display("FAIL prio_d_gnt cyc=%0d got=%0b exp=%0b", k, d_gnt, !cs); end
    end
    total++; if (txns < 5) begin bad++; $display("FAIL prio_txn_count got=%0d exp>=5", txns); end
    f_req = 1'b0; d_req = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    settle();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'($urandom);
    for (int k = 1; k <= 30; k++) begin
      step();
      d_req   = 1'b0;
      rst     = (k == 5);
      wr_data = 4'($urandom);
      sqi_in  = 4'($urandom);
      #1;
      if (k == 5) begin
        total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL rm_gnt_before cyc=%0d got=%0b exp=1", k, d_gnt); end
      end else if (k == 6) begin
        total++; if (cs !== 1'b1)    begin bad++; $display("FAIL rm_cs cyc=%0d got=%0b exp=1", k, cs); end
        total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL rm_d_gnt cyc=%0d got=%0b exp=0", k, d_gnt); end
        total++; if (f_gnt !== 1'b0) begin bad++; $display("FAIL rm_f_gnt cyc=%0d got=%0b exp=0", k, f_gnt); end
        total++; if (mode !== 1'b0)  begin bad++; $display("FAIL rm_mode cyc=%0d got=%0b exp=0", k, mode); end
      end else if (k > 6) begin
        total++; if (wr_acp !== 1'b0) begin bad++; $display("FAIL rm_wr_acp cyc=%0d got=%0b exp=0", k, wr_acp); end
        total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL rm_rd_vld cyc=%0d got=%0b exp=0", k, rd_vld); end
        total++; if (cs !== 1'b1)     begin bad++; $display("FAIL rm_cs_idle cyc=%0d got=%0b exp=1", k, cs); end
      end
    end
    rst = 1'b0; d_wr = 1'b0;
  endtask

  task automatic test_random();
    bit act, own_d, wr, last_d, pv, in_data, cont, oreq, xreq;
    bit e_mode, e_wl, e_acp, chk_dat;
    logic [23:0] ba, sh;
    logic [3:0]  pd, e_dat;
    int cyc, words, d, ds;
    step();
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0;
    act = 1'b0; pv = 1'b0; last_d = 1'b0; own_d = 1'b0; wr = 1'b0;
    cyc = 0; words = 0; ba = 24'h0; pd = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      step();
      rst     = ($urandom_range(0, 399) == 0);
      f_req   = ($urandom_range(0, 2) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      d_wr    = 1'($urandom);
      f_addr  = 16'($urandom);
      d_addr  = 16'($urandom);
      sqi_in  = 4'($urandom);
      wr_data = 4'($urandom);
      #1;
      ds      = wr ? 8 : 10;
      in_data = act && (cyc >= ds);
      d       = cyc - ds;
      e_wl    = in_data && ((d % 4) == 3);
      e_acp   = in_data && wr;
      e_mode  = act && ((cyc < 8) || (wr && in_data));
      chk_dat = act && !(in_data && !wr);
      if (cyc == 0)      e_dat = 4'h0;
      else if (cyc == 1) e_dat = wr ? 4'h2 : 4'h3;
      else if (cyc < 8) begin sh = ba >> (4 * (7 - cyc)); e_dat = sh[3:0]; end
      else if (!in_data) e_dat = 4'h0;
      else               e_dat = wr_data;
      total++; if (cs !== !act)            begin bad++; $display("FAIL rnd_cs n=%0d got=%0b exp=%0b", n, cs, !act); end
      total++; if (sck !== act)            begin bad++; $display("FAIL rnd_sck n=%0d got=%0b exp=%0b", n, sck, act); end
      total++; if (mode !== e_mode)        begin bad++; $display("FAIL rnd_mode n=%0d got=%0b exp=%0b", n, mode, e_mode); end
      total++; if (f_gnt !== (act && !own_d)) begin bad++; $display("FAIL rnd_f_gnt n=%0d got=%0b exp=%0b", n, f_gnt, act && !own_d); end
      total++; if (d_gnt !== (act && own_d))  begin bad++; $display("FAIL rnd_d_gnt n=%0d got=%0b exp=%0b", n, d_gnt, act && own_d); end
      total++; if (wr_acp !== e_acp)       begin bad++; $display("FAIL rnd_wr_acp n=%0d got=%0b exp=%0b", n, wr_acp, e_acp); end
      total++; if (word_last !== e_wl)     begin bad++; $display("FAIL rnd_word_last n=%0d got=%0b exp=%0b", n, word_last, e_wl); end
      total++; if (rd_vld !== pv)          begin bad++; $display("FAIL rnd_rd_vld n=%0d got=%0b exp=%0b", n, rd_vld, pv); end
      if (pv) begin
        total++; if (rd_data !== pd) begin bad++; $display("FAIL rnd_rd_data n=%0d got=%0h exp=%0h", n, rd_data, pd); end
      end
      if (chk_dat) begin
        total++; if (sqi_out !== e_dat) begin bad++; $display("FAIL rnd_sqi_data n=%0d got=%0h exp=%0h", n, sqi_out, e_dat); end
      end
      // advance the model with the inputs the DUT samples at the next edge
      if (rst) begin
        act = 1'b0; pv = 1'b0; last_d = 1'b0;
      end else begin
        pv = in_data && !wr;
        pd = sqi_in;
        if (act) begin
          if (e_wl) begin
            words++;
            oreq = own_d ? d_req : f_req;
            xreq = own_d ? f_req : d_req;
`ifdef IDLI_SQI_ARB_FAIR_EN
            cont = oreq && !(xreq && (words >= MB));
`else
            cont = oreq;
`endif
            if (cont) cyc++;
            else act = 1'b0;
          end else begin
            cyc++;
          end
        end else if (f_req || d_req) begin
`ifdef IDLI_SQI_ARB_FAIR_EN
          own_d = (f_req && d_req) ? !last_d : d_req;
`else
          own_d = d_req;
`endif
          last_d = own_d;
          act    = 1'b1;
          cyc    = 0;
          words  = 0;
          wr     = own_d && d_wr;
          ba     = {7'b0, (own_d ? d_addr : f_addr), 1'b0};
        end
      end
    end
    rst = 1'b0; f_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    f_addr = 16'h0; d_addr = 16'h0; wr_data = 4'h0; sqi_in = 4'h0;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_burst();
`ifdef IDLI_SQI_ARB_FAIR_EN
    test_fair();
`else
    test_prio();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
